operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/register data width.
REQ-002 Parameter INDEX_WIDTH, default 5, register index width (2^INDEX_WIDTH registers, index 0 hardwired zero).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 inValid  input  1  decoded instruction present on in* fields.
REQ-006 inReady  output  1  stage accepts instruction this cycle.
REQ-007 rsIndex, rtIndex, rdIndex  input  INDEX_WIDTH each  source A, source B, destination register.
REQ-008 regWriteD  input  1  instruction writes rdIndex.
REQ-009 rfIndexA, rfIndexB  output  INDEX_WIDTH each  register file read addresses (combinational copy of rsIndex/rtIndex).
REQ-010 rfDataA, rfDataB  input  DATA_WIDTH each  register file read data, combinational same cycle.
REQ-011 regWriteW  input  1  writeback stage writes this cycle.
REQ-012 writeIndexW  input  INDEX_WIDTH  writeback destination.
REQ-013 writeValueW  input  DATA_WIDTH  writeback value.
REQ-014 outValid  output  1  registered instruction valid toward execute.
REQ-015 outReady  input  1  execute accepts registered instruction.
REQ-016 operandA, operandB  output  DATA_WIDTH each  registered operands.
REQ-017 destIndexE  output  INDEX_WIDTH; regWriteE  output  1  registered destination and write flag.
REQ-018 flush  input  1  discard registered instruction.
REQ-019 stallCount  output  16  saturating count of hazard-stall cycles.

Function
REQ-020 Scoreboard: one pending bit per register; bit 0 always 0.
REQ-021 hazard = inValid and, for rsIndex or rtIndex nonzero, pending bit set and not (regWriteW and writeIndexW equals that index).
REQ-022 inReady = (not outValid or outReady) and not hazard and not flush.
REQ-023 Accept = inValid and inReady; on accept, output register loads operands, rdIndex, regWriteD, outValid=1, next edge.
REQ-024 Operand select per source: index 0 -> 0; else regWriteW and writeIndexW match -> writeValueW (bypass); else rfData.
REQ-025 Output side: outValid and outReady without accept -> outValid=0; with accept -> new instruction loaded (back-to-back, one per cycle).
REQ-026 Not outReady and outValid -> output register holds all fields unchanged.
REQ-027 Latency: accepted instruction appears on outputs exactly 1 cycle after accept.
REQ-028 Pending set: on accept with regWriteD=1 and rdIndex nonzero, pending[rdIndex]=1.
REQ-029 Pending clear: regWriteW=1 -> pending[writeIndexW]=0.
REQ-030 Same register set and cleared in one cycle -> set wins.
REQ-031 flush=1: outValid=0 next edge; if outValid and regWriteE and destIndexE nonzero, pending[destIndexE]=0 unless same-cycle set to that index (none possible, inReady=0).
REQ-032 flush takes priority over outReady hold; no accept during flush.
REQ-033 stallCount increments by 1 each cycle hazard=1; saturates at 16'hFFFF.
REQ-034 regWriteW with writeIndexW=0 has no scoreboard effect and no bypass.

Reset
REQ-035 reset=1: outValid=0, operandA=0, operandB=0, destIndexE=0, regWriteE=0, all pending bits 0, stallCount=0, asynchronously.
REQ-036 reset asserted mid-stall or with outValid=1 discards instruction; first accept possible on first edge after reset deasserts.

Verification
REQ-037 Reset, then rs=1, rt=2, rd=3, regWriteD=1, rfDataA=5, rfDataB=7, outReady=1 -> next cycle outValid=1, operandA=5, operandB=7, destIndexE=3, pending[3]=1.
REQ-038 After REQ-037, next instruction rs=3 with no writeback -> inReady=0, stallCount increments each cycle; then regWriteW=1, writeIndexW=3, writeValueW=32'h00020000 -> accept same cycle, operandA=32'h00020000 next cycle, pending[3]=0.
REQ-039 rs=0, rt=0, rfData=32'hFFFFFFFF -> operandA=operandB=0; rd=0 with regWriteD=1 -> no pending bit set.
REQ-040 outReady=0 with outValid=1 and new inValid -> inReady=0, outputs held; outReady=1 -> new instruction loaded next cycle.
REQ-041 flush with registered rd=4 pending -> outValid=0, pending[4]=0; following rs=4 instruction accepted without stall.
REQ-042 Hold hazard 70000 cycles -> stallCount stops at 16'hFFFF; reset mid-hazard -> stallCount=0 and outValid=0 immediately.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources from the register file, bypasses the
// same-cycle writeback, tracks in-flight destinations in a scoreboard and
// stalls on read-after-write hazards. A single output register feeds execute.
module operand_fetch #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,

    // Decoded instruction
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [INDEX_WIDTH-1:0] rsIndex,
    input  logic [INDEX_WIDTH-1:0] rtIndex,
    input  logic [INDEX_WIDTH-1:0] rdIndex,
    input  logic                   regWriteD,

    // Register file read ports
    output logic [INDEX_WIDTH-1:0] rfIndexA,
    output logic [INDEX_WIDTH-1:0] rfIndexB,
    input  logic [DATA_WIDTH-1:0]  rfDataA,
    input  logic [DATA_WIDTH-1:0]  rfDataB,

    // Writeback
    input  logic                   regWriteW,
    input  logic [INDEX_WIDTH-1:0] writeIndexW,
    input  logic [DATA_WIDTH-1:0]  writeValueW,

    // Toward execute
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_WIDTH-1:0]  operandA,
    output logic [DATA_WIDTH-1:0]  operandB,
    output logic [INDEX_WIDTH-1:0] destIndexE,
    output logic                   regWriteE,

    input  logic                   flush,
    output logic [15:0]            stallCount
);

    localparam int unsigned NumRegs = 1 << INDEX_WIDTH;

    // Scoreboard and output register state
    logic [NumRegs-1:0]     pending_q, pending_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  operand_a_q, operand_a_d;
    logic [DATA_WIDTH-1:0]  operand_b_q, operand_b_d;
    logic [INDEX_WIDTH-1:0] dest_index_q, dest_index_d;
    logic                   reg_write_q, reg_write_d;
    logic [15:0]            stall_count_q, stall_count_d;

    // Combinational decode
    logic                   wb_active;
    logic                   bypass_a, bypass_b;
    logic                   hazard_a, hazard_b, hazard;
    logic                   in_ready;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  sel_a, sel_b;

    assign rfIndexA = rsIndex;
    assign rfIndexB = rtIndex;

    // Hazard detection, bypass selection and handshake
    always_comb begin
        // Writes to register 0 are invisible to both scoreboard and bypass.
        wb_active = regWriteW && (writeIndexW != '0);
        bypass_a  = wb_active && (writeIndexW == rsIndex);
        bypass_b  = wb_active && (writeIndexW == rtIndex);

        // A pending source is fine if its value is arriving this very cycle.
        hazard_a  = (rsIndex != '0) && pending_q[rsIndex] && !bypass_a;
        hazard_b  = (rtIndex != '0) && pending_q[rtIndex] && !bypass_b;
        hazard    = inValid && (hazard_a || hazard_b);

        in_ready  = (!out_valid_q || outReady) && !hazard && !flush;
        accept    = inValid && in_ready;

        if (rsIndex == '0) begin
            sel_a = '0;
        end else if (bypass_a) begin
            sel_a = writeValueW;
        end else begin
            sel_a = rfDataA;
        end

        if (rtIndex == '0) begin
            sel_b = '0;
        end else if (bypass_b) begin
            sel_b = writeValueW;
        end else begin
            sel_b = rfDataB;
        end
    end

    assign inReady = in_ready;

    // Output register next state: flush beats accept beats drain beats hold
    always_comb begin
        out_valid_d  = out_valid_q;
        operand_a_d  = operand_a_q;
        operand_b_d  = operand_b_q;
        dest_index_d = dest_index_q;
        reg_write_d  = reg_write_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            operand_a_d  = sel_a;
            operand_b_d  = sel_b;
            dest_index_d = rdIndex;
            reg_write_d  = regWriteD;
        end else if (outReady) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard next state; sets are applied last so a same-cycle set wins
    always_comb begin
        pending_d = pending_q;

        if (wb_active) begin
            pending_d[writeIndexW] = 1'b0;
        end

        // A flushed instruction will never write back, so release its claim.
        if (flush && out_valid_q && reg_write_q && (dest_index_q != '0)) begin
            pending_d[dest_index_q] = 1'b0;
        end

        if (accept && regWriteD && (rdIndex != '0)) begin
            pending_d[rdIndex] = 1'b1;
        end

        pending_d[0] = 1'b0;
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q     <= '0;
            out_valid_q   <= 1'b0;
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            dest_index_q  <= '0;
            reg_write_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            pending_q     <= pending_d;
            out_valid_q   <= out_valid_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            dest_index_q  <= dest_index_d;
            reg_write_q   <= reg_write_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign outValid   = out_valid_q;
    assign operandA   = operand_a_q;
    assign operandB   = operand_b_q;
    assign destIndexE = dest_index_q;
    assign regWriteE  = reg_write_q;
    assign stallCount = stall_count_q;

endmodule
